float_to_pif_pipe: RTL and testbench
====================================

Name: float_to_pif_pipe

Overview:
Pipelined, handshaked successor to the combinational float-to-PIF decoder. Accepts one IEEE-754 binary16/32/64 word per cycle and emits a PIF word {sign, unbiased exponent, fraction without hidden bit}. Subnormal inputs are fully normalised, and special values are classified. Sits between the float-side input FIFO and the PPU datapath front end.

Parameters:
FSIZE, 32, float width; legal values 16, 32, 64. Any other value is an elaboration error.
E (derived), 5/8/11, float exponent width for FSIZE 16/32/64.
M (derived), 10/23/52, float fraction width.
BIAS (derived), 2^(E-1)-1.
PIF_EXP_W (derived), E+1, signed PIF exponent width. This covers the minimum subnormal exponent (-24/-149/-1074).
PIF_W (derived), 1+PIF_EXP_W+M.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept input this cycle
in_bits  in  FSIZE  IEEE-754 word
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output
out_pif  out  PIF_W  {sign, exp[PIF_EXP_W-1:0] two's complement, frac[M-1:0]}
out_is_zero  out  1  input was +0 or -0
out_is_inf  out  1  input was +/-infinity
out_is_nan  out  1  input was NaN
out_was_sub  out  1  input was subnormal (normalised on output)

Behaviour:
- Reset, asynchronous, active while rst=1:
  - both stage valids = 0, so out_valid = 0;
  - out_pif = 0 and all flags = 0;
  - in_ready = 1 once rst deasserts.
  - A word in flight when rst asserts is dropped, with no partial output.
- Two register stages: S1 (decode, classify, leading-one detect) and S2 (normalise, output register). Latency is exactly 2 cycles from the accepting in_valid&&in_ready edge to out_valid, when unstalled. Throughput is 1 word/cycle.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances. This is combinational from out_ready; bubbles collapse.
  - out_pif and flags are stable while out_valid && !out_ready.
  - in_bits is sampled only on an accepting cycle.
- Decode: sign = bit FSIZE-1; ef = exponent field; f = fraction field.
- Classification, mutually exclusive:
  - zero: ef=0, f=0 → exp=0, frac=0, sign preserved, out_is_zero=1.
  - subnormal: ef=0, f≠0.
    - p = index of the most significant 1 in f (0..M-1).
    - exp = p - BIAS + 1 - M.
    - frac = (f << (M-p)) truncated to M bits.
    - out_was_sub=1.
  - normal: 0<ef<2^E-1 → exp = ef - BIAS, sign-extended to PIF_EXP_W; frac = f.
  - inf: ef all ones, f=0 → exp = 2^(E-1), frac=0, out_is_inf=1.
  - NaN: ef all ones, f≠0 → exp = 2^(E-1), frac = f unchanged (payload preserved), out_is_nan=1.
- Arithmetic:
  - All exponent math is signed, PIF_EXP_W wide; no overflow is possible by construction.
  - Leading-one detect uses a priority encoder over M bits and is registered in S1.
  - The barrel shift is done in S2.
- Simultaneous events:
  - Input accept and output drain on the same cycle are both honoured.
  - When full and stalled (both stages valid, out_ready=0), in_ready=0 and nothing is overwritten.

Test Plan:
1. FSIZE=32; stream 0x3F800000, 0xC0200000, 0x7F7FFFFF back-to-back, out_ready=1 → outputs arrive at cycles +2,+3,+4:
   - {0, 0, 0x000000};
   - {1, 1, 0x200000};
   - {0, 127, 0x7FFFFF}.
   All flags 0.
2. FSIZE=32 subnormals:
   - 0x00000001 → exp=-149, frac=0, out_was_sub=1.
   - 0x00400000 → exp=-127, frac=0.
   - 0x00600000 → exp=-127, frac=0x400000.
3. Specials, FSIZE=32:
   - 0x80000000 → sign=1, exp=0, out_is_zero=1.
   - 0x7F800000 → exp=128, out_is_inf=1.
   - 0x7FC00001 → exp=128, frac=0x400001, out_is_nan=1.
4. Backpressure: send 4 words with out_ready held 0 → in_ready drops after 2 accepts. Release out_ready → all 4 words emerge in order, none lost or duplicated, and out_pif stays stable during the stall.
5. Reset mid-stream: assert rst with both stages valid → out_valid falls immediately (asynchronous). After deassert, the first new input appears 2 cycles after acceptance with no stale data.
6. FSIZE=16 and FSIZE=64:
   - 0x0001 (fp16) → exp=-24.
   - 0x0000000000000001 (fp64) → exp=-1074.
   - 0x3FF0000000000000 → exp=0, frac=0.
   - Random 10k-vector regression against a reference model matches bit-exactly.

Source files
------------

// File: rtl/float_to_pif_pipe.sv
// float_to_pif_pipe: two-stage handshaked IEEE-754 binary16/32/64 to PIF converter.
// S1 decodes, classifies and finds the leading one of the fraction; S2 normalises
// subnormals with a barrel shift and holds the output word until it is taken.
module float_to_pif_pipe #(
  parameter  int FSIZE     = 32,
  localparam int E         = (FSIZE == 16) ? 5 : (FSIZE == 64) ? 11 : 8,
  localparam int M         = FSIZE - 1 - E,
  localparam int PIF_EXP_W = E + 1,
  localparam int PIF_W     = 1 + PIF_EXP_W + M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FSIZE-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIF_W-1:0] out_pif,
  output logic             out_is_zero,
  output logic             out_is_inf,
  output logic             out_is_nan,
  output logic             out_was_sub
);

  localparam int BIAS        = (1 << (E - 1)) - 1;
  localparam int PW          = $clog2(M);
  localparam int SUB_OFF     = BIAS + M - 1;
  localparam int EXP_SPECIAL = 1 << (E - 1);

  if (!(FSIZE == 16 || FSIZE == 32 || FSIZE == 64)) begin : g_bad_fsize
    $error("float_to_pif_pipe: FSIZE must be 16, 32 or 64");
  end

  // Input field split
  logic                 sign_in;
  logic [E-1:0]         ef;
  logic [M-1:0]         f;
  logic                 ef_zero, ef_ones, f_zero;
  logic [PW-1:0]        lead;
  logic [PIF_EXP_W-1:0] dec_exp;

  assign sign_in = in_bits[FSIZE-1];
  assign ef      = in_bits[FSIZE-2 -: E];
  assign f       = in_bits[M-1:0];
  assign ef_zero = (ef == '0);
  assign ef_ones = &ef;
  assign f_zero  = (f == '0);

  // Stage state
  logic                 s1_valid;
  logic                 s1_sign;
  logic [PIF_EXP_W-1:0] s1_exp;
  logic [M-1:0]         s1_frac;
  logic [PW-1:0]        s1_lead;
  logic                 s1_zero, s1_inf, s1_nan, s1_sub;
  logic                 s1_adv, s2_adv;

  // A stage may take a new word when it is empty or its word is leaving this cycle
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Priority encoder: the highest set fraction bit wins
  always_comb begin
    lead = '0;
    for (int i = 0; i < M; i++) begin
      if (f[i]) lead = PW'(i);
    end
  end

  // Exponent for every class except subnormal, which S2 derives from the leading-one index
  always_comb begin
    if (ef_ones)      dec_exp = PIF_EXP_W'(EXP_SPECIAL);
    else if (ef_zero) dec_exp = '0;
    else              dec_exp = {1'b0, ef} - PIF_EXP_W'(BIAS);
  end

  // S1 register: capture the decoded word only on an accepting cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_lead  <= '0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_sub   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sign_in;
        s1_exp  <= dec_exp;
        s1_frac <= f;
        s1_lead <= lead;
        s1_zero <= ef_zero && f_zero;
        s1_sub  <= ef_zero && !f_zero;
        s1_inf  <= ef_ones && f_zero;
        s1_nan  <= ef_ones && !f_zero;
      end
    end
  end

  // Subnormal normalisation: shift the leading one out past the top, rebase the exponent
  logic [PW-1:0]        shamt;
  logic [M-1:0]         sub_frac;
  logic [PIF_EXP_W-1:0] sub_exp;

  assign shamt    = PW'(M - 1) - s1_lead;
  assign sub_frac = (s1_frac << 1) << shamt;
  assign sub_exp  = PIF_EXP_W'(s1_lead) - PIF_EXP_W'(SUB_OFF);

  // S2 output register: loads when it advances, otherwise holds the presented word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pif     <= '0;
      out_is_zero <= 1'b0;
      out_is_inf  <= 1'b0;
      out_is_nan  <= 1'b0;
      out_was_sub <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pif     <= {s1_sign, (s1_sub ? sub_exp : s1_exp), (s1_sub ? sub_frac : s1_frac)};
        out_is_zero <= s1_zero;
        out_is_inf  <= s1_inf;
        out_is_nan  <= s1_nan;
        out_was_sub <= s1_sub;
      end
    end
  end

endmodule

// File: tb/tb_float_to_pif_pipe.sv
// tb_float_to_pif_pipe: scoreboard bench for float_to_pif_pipe at FSIZE 16, 32 and 64.
// Stimulus pushes expected PIF words per instance; an independent monitor compares
// whatever each instance presents against the head of its queue.
module tb_float_to_pif_pipe;

  localparam int QSZ = 1024;
  localparam logic [3:0] FZ = 4'b1000, FI = 4'b0100, FN = 4'b0010, FS = 4'b0001;

  logic        clk;
  logic [2:0]  rstv;
  logic [2:0]  inValid;
  logic [63:0] inBits [3];
  logic        outReady;
  wire  [2:0]  inReady, outValid, isZero, isInf, isNan, wasSub;
  wire  [16:0] pif16;
  wire  [32:0] pif32;
  wire  [64:0] pif64;
  wire  [79:0] outPifX [3];
  wire  [3:0]  outFlg [3];

  float_to_pif_pipe #(.FSIZE(16)) dut16 (
    .clk(clk), .rst(rstv[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_bits(inBits[0][15:0]), .out_valid(outValid[0]), .out_ready(outReady),
    .out_pif(pif16), .out_is_zero(isZero[0]), .out_is_inf(isInf[0]),
    .out_is_nan(isNan[0]), .out_was_sub(wasSub[0]));

  float_to_pif_pipe #(.FSIZE(32)) dut32 (
    .clk(clk), .rst(rstv[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_bits(inBits[1][31:0]), .out_valid(outValid[1]), .out_ready(outReady),
    .out_pif(pif32), .out_is_zero(isZero[1]), .out_is_inf(isInf[1]),
    .out_is_nan(isNan[1]), .out_was_sub(wasSub[1]));

  float_to_pif_pipe #(.FSIZE(64)) dut64 (
    .clk(clk), .rst(rstv[2]), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_bits(inBits[2]), .out_valid(outValid[2]), .out_ready(outReady),
    .out_pif(pif64), .out_is_zero(isZero[2]), .out_is_inf(isInf[2]),
    .out_is_nan(isNan[2]), .out_was_sub(wasSub[2]));

  assign outPifX[0] = {63'd0, pif16};
  assign outPifX[1] = {47'd0, pif32};
  assign outPifX[2] = {15'd0, pif64};
  for (genvar g = 0; g < 3; g++) begin : g_flags
    assign outFlg[g] = {isZero[g], isInf[g], isNan[g], wasSub[g]};
  end

  // Scoreboard storage, one ring per instance
  logic [79:0] expPif   [3][QSZ];
  logic [3:0]  expFlg   [3][QSZ];
  int          expStamp [3][QSZ];
  bit          expLat   [3][QSZ];
  int          wrPtr [3] = '{0, 0, 0};
  int          rdPtr [3] = '{0, 0, 0};
  int          idleCnt [3] = '{0, 0, 0};

  int  nChecks = 0;
  int  nFails  = 0;
  int  cycleCnt = 0;
  int  readyMode = 0;
  bit  probeReq = 0;
  int  probeAccepts = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycleCnt++;
    end
  end

  // Downstream ready: 0 = always ready, 1 = stalled, 2 = random backpressure
  initial begin
    outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = 1'b0;
        default: outReady = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic int expW(input int fs);
    return (fs == 16) ? 5 : (fs == 32) ? 8 : 11;
  endfunction

  function automatic int fsIdx(input int fs);
    return (fs == 16) ? 0 : (fs == 32) ? 1 : 2;
  endfunction

  function automatic logic [79:0] packPif(input int fs, input bit sign, input longint ex,
                                          input logic [63:0] fr);
    int e = expW(fs);
    int m = fs - 1 - e;
    logic [79:0] em;
    em = 80'(ex) & ((80'd1 << (e + 1)) - 80'd1);
    return (80'(sign) << (e + 1 + m)) | (em << m) | 80'(fr);
  endfunction

  // Value-level decode: a subnormal f*2^(1-bias-m) is rewritten as 2^x*(1+r)
  task automatic refModel(input int fs, input logic [63:0] bits,
                          output logic [79:0] pif, output logic [3:0] flg);
    int e = expW(fs);
    int m = fs - 1 - e;
    longint bias = (longint'(1) << (e - 1)) - 1;
    logic [63:0] ef = (bits >> m) & ((64'd1 << e) - 64'd1);
    logic [63:0] f  = bits & ((64'd1 << m) - 64'd1);
    bit sign = bits[fs-1];
    longint ex;
    logic [63:0] fr;
    int p;
    if (ef == 0 && f == 0) begin
      ex = 0; fr = 0; flg = FZ;
    end else if (ef == 0) begin
      p = 0;
      while ((f >> (p + 1)) != 0) p++;
      ex = longint'(p) + 1 - bias - m;
      fr = (f - (64'd1 << p)) << (m - p);
      flg = FS;
    end else if (ef == (64'd1 << e) - 64'd1) begin
      ex = longint'(1) << (e - 1);
      fr = f;
      flg = (f == 0) ? FI : FN;
    end else begin
      ex = longint'(ef) - bias;
      fr = f;
      flg = 4'b0000;
    end
    pif = packPif(fs, sign, ex, fr);
  endtask

  function automatic logic [63:0] randWord(input int fs);
    int e = expW(fs);
    int m = fs - 1 - e;
    logic [63:0] ef, f;
    case ($urandom_range(0, 3))
      0:       ef = 64'd0;
      1:       ef = (64'd1 << e) - 64'd1;
      default: ef = {$urandom, $urandom} & ((64'd1 << e) - 64'd1);
    endcase
    case ($urandom_range(0, 3))
      0:       f = 64'd0;
      1:       f = 64'd1 << $urandom_range(0, m - 1);
      default: f = {$urandom, $urandom} & ((64'd1 << m) - 64'd1);
    endcase
    return (64'($urandom_range(0, 1)) << (fs - 1)) | (ef << m) | f;
  endfunction

  // ---------------- stimulus ----------------
  // Called and returns at posedge+2; in_ready is sampled at posedge+3
  task automatic offerWord(input int idx, input logic [63:0] bits, input logic [79:0] pif,
                           input logic [3:0] flg, input int maxCycles, output bit accepted);
    int slot;
    accepted = 0;
    inBits[idx] = bits;
    inValid[idx] = 1'b1;
    for (int c = 0; c < maxCycles && !accepted; c++) begin
      #1;
      if (inReady[idx]) begin
        accepted = 1;
        slot = wrPtr[idx] % QSZ;
        expPif[idx][slot]   = pif;
        expFlg[idx][slot]   = flg;
        expStamp[idx][slot] = cycleCnt + 2;
        expLat[idx][slot]   = (readyMode == 0);
        wrPtr[idx]++;
      end
      @(posedge clk);
      #2;
    end
    inValid[idx] = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input logic [63:0] bits,
                               input logic [79:0] pif, input logic [3:0] flg);
    bit ok;
    offerWord(idx, bits, pif, flg, 400, ok);
    if (!ok) begin
      $display("[TB] FAIL accept_timeout inst=%0d: in_ready stayed 0, required 1 within 400 cycles", idx);
      $fatal(1, "[TB] input never accepted");
    end
  endtask

  task automatic applyDirected(input int fs, input logic [63:0] bits, input bit sign,
                               input longint ex, input logic [63:0] fr, input logic [3:0] flg);
    applyStimulus(fsIdx(fs), bits, packPif(fs, sign, ex, fr), flg);
  endtask

  task automatic applyRandom(input int fs, input logic [63:0] bits);
    logic [79:0] pif;
    logic [3:0]  flg;
    refModel(fs, bits, pif, flg);
    applyStimulus(fsIdx(fs), bits, pif, flg);
  endtask

  // ---------------- monitor ----------------
  task automatic checkOutput(input int i);
    int slot;
    bit popped = 0;
    if (rstv[i]) begin
      nChecks++;
      if (outValid[i] !== 1'b0 || outPifX[i] !== 80'd0 || outFlg[i] !== 4'd0) begin
        nFails++;
        $display("[TB] FAIL reset_state inst=%0d: valid=%b pif=%h flags=%b, required 0/0/0",
                 i, outValid[i], outPifX[i], outFlg[i]);
      end
      rdPtr[i] = wrPtr[i];
      idleCnt[i] = 0;
      return;
    end
    if (outValid[i]) begin
      nChecks++;
      if (rdPtr[i] == wrPtr[i]) begin
        nFails++;
        $display("[TB] FAIL unexpected_output inst=%0d: got pif=%h flags=%b, required no output",
                 i, outPifX[i], outFlg[i]);
      end else begin
        slot = rdPtr[i] % QSZ;
        if (outPifX[i] !== expPif[i][slot] || outFlg[i] !== expFlg[i][slot]) begin
          nFails++;
          $display("[TB] FAIL data inst=%0d: got pif=%h flags=%b, required pif=%h flags=%b",
                   i, outPifX[i], outFlg[i], expPif[i][slot], expFlg[i][slot]);
        end
        if (expLat[i][slot]) begin
          nChecks++;
          if (cycleCnt != expStamp[i][slot]) begin
            nFails++;
            $display("[TB] FAIL latency inst=%0d: output at cycle %0d, required cycle %0d",
                     i, cycleCnt, expStamp[i][slot]);
          end
        end
        if (outReady) begin
          rdPtr[i]++;
          popped = 1;
        end
      end
    end
    if (rdPtr[i] != wrPtr[i] && !popped) idleCnt[i]++;
    else idleCnt[i] = 0;
    if (idleCnt[i] > 300) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL output_timeout inst=%0d: %0d words still pending after 300 cycles, required 0",
               i, wrPtr[i] - rdPtr[i]);
      rdPtr[i] = wrPtr[i];
      idleCnt[i] = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) checkOutput(i);
      if (probeReq) begin
        nChecks++;
        if (probeAccepts != 2) begin
          nFails++;
          $display("[TB] FAIL stall_accepts: %0d words accepted while stalled, required 2", probeAccepts);
        end
        nChecks++;
        if (inReady[1] !== 1'b0) begin
          nFails++;
          $display("[TB] FAIL stall_in_ready: in_ready=%b while full and stalled, required 0", inReady[1]);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    int nAcc;
    logic [63:0] w [4];
    logic [79:0] p [4];
    logic [3:0]  fl [4];
    bit allEmpty;

    rstv = 3'b111;
    inValid = 3'b000;
    for (int i = 0; i < 3; i++) inBits[i] = 64'd0;
    repeat (3) @(posedge clk);
    #2;
    rstv = 3'b000;

    // Normals back to back, then subnormals and specials at FSIZE=32
    applyDirected(32, 64'h3F80_0000, 0, 0,    64'h00_0000, 4'b0000);
    applyDirected(32, 64'hC020_0000, 1, 1,    64'h20_0000, 4'b0000);
    applyDirected(32, 64'h7F7F_FFFF, 0, 127,  64'h7F_FFFF, 4'b0000);
    applyDirected(32, 64'h0000_0001, 0, -149, 64'h00_0000, FS);
    applyDirected(32, 64'h0040_0000, 0, -127, 64'h00_0000, FS);
    applyDirected(32, 64'h0060_0000, 0, -127, 64'h40_0000, FS);
    applyDirected(32, 64'h8000_0000, 1, 0,    64'h00_0000, FZ);
    applyDirected(32, 64'h7F80_0000, 0, 128,  64'h00_0000, FI);
    applyDirected(32, 64'h7FC0_0001, 0, 128,  64'h40_0001, FN);
    // FSIZE=16 and FSIZE=64 boundaries
    applyDirected(16, 64'h0001, 0, -24, 64'h000, FS);
    applyDirected(16, 64'h3C00, 0, 0,   64'h000, 4'b0000);
    applyDirected(16, 64'hFC00, 1, 16,  64'h000, FI);
    applyDirected(64, 64'h0000_0000_0000_0001, 0, -1074, 64'd0, FS);
    applyDirected(64, 64'h3FF0_0000_0000_0000, 0, 0,     64'd0, 4'b0000);
    applyDirected(64, 64'h8000_0000_0000_0000, 1, 0,     64'd0, FZ);
    repeat (4) @(posedge clk);
    #2;

    // Backpressure: only two words fit while the output is stalled
    readyMode = 1;
    @(posedge clk);
    #2;
    for (int k = 0; k < 4; k++) begin
      w[k] = randWord(32);
      refModel(32, w[k], p[k], fl[k]);
    end
    nAcc = 0;
    for (int k = 0; k < 3; k++) begin
      offerWord(1, w[k], p[k], fl[k], (k < 2) ? 1 : 4, acc);
      if (acc) nAcc++;
    end
    probeAccepts = nAcc;
    probeReq = 1;
    @(posedge clk);
    #2;
    probeReq = 0;
    readyMode = 0;
    applyStimulus(1, w[2], p[2], fl[2]);
    applyStimulus(1, w[3], p[3], fl[3]);
    repeat (4) @(posedge clk);
    #2;

    // Reset with both stages full, then a fresh word must come out cleanly
    readyMode = 1;
    @(posedge clk);
    #2;
    applyRandom(32, randWord(32));
    applyRandom(32, randWord(32));
    rstv[1] = 1'b1;
    readyMode = 0;
    repeat (2) @(posedge clk);
    #2;
    rstv[1] = 1'b0;
    applyDirected(32, 64'hC020_0000, 1, 1, 64'h20_0000, 4'b0000);
    repeat (4) @(posedge clk);
    #2;

    // Randomised regression with random backpressure and input bubbles
    readyMode = 2;
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 3400; n++) begin
        applyRandom((s == 0) ? 16 : (s == 1) ? 32 : 64, randWord((s == 0) ? 16 : (s == 1) ? 32 : 64));
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk);
          #2;
        end
      end
    end
    readyMode = 0;

    allEmpty = 0;
    for (int c = 0; c < 400 && !allEmpty; c++) begin
      @(posedge clk);
      #2;
      allEmpty = (rdPtr[0] == wrPtr[0]) && (rdPtr[1] == wrPtr[1]) && (rdPtr[2] == wrPtr[2]);
    end
    if (!allEmpty) begin
      $display("[TB] FAIL drain_timeout: words still pending at end, required none");
      $fatal(1, "[TB] scoreboard did not drain");
    end
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
